// File: rtl/adder_mul_seq.sv
//-----------------------------------------------------------------------------
// adder_mul_seq
//
// Multi-cycle 32x32 unsigned shift-add multiplier. It has no adder of its
// own: for every iteration it borrows the execute stage's shared 32-bit
// carry-select adder through the o_adder*/i_adder* ports. One request is
// accepted through a valid/ready handshake. The 64-bit product is returned
// through a second valid/ready handshake.
//
// Optional build macro:
//   ADDER_MUL_EARLY_TERM_EN - When defined, the block finishes early once
//                             all remaining multiplier bits are zero. It
//                             aligns the partial product with a single
//                             right shift. The product values do not change.
//
// Ports:
//   i_clk_1            in   1   clock, rising edge
//   i_rstN_1           in   1   asynchronous active-low reset
//   i_inValid_1        in   1   request valid
//   o_inReady_1        out  1   block can accept a request (IDLE)
//   i_mulOperand1_32   in  32   multiplicand
//   i_mulOperand2_32   in  32   multiplier
//   o_outValid_1       out  1   product valid (DONE)
//   i_outReady_1       in   1   consumer accepts product
//   o_mulProduct_64    out 64   unsigned product; holds its last value
//   o_busy_1           out  1   high in CALC or DONE
//   o_adderOperand1_32 out 32   shared adder operand 1 (0 outside CALC)
//   o_adderOperand2_32 out 32   shared adder operand 2 (0 outside CALC)
//   o_adderCIn_1       out  1   shared adder carry-in, always 0
//   i_adderSum_32      in  32   shared adder sum
//   i_adderCOut_1      in   1   shared adder carry-out
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module adder_mul_seq #(
   parameter int ITERS = 32,  // iterations per multiply; must equal adder width
   parameter int CNT_W = 6    // iteration counter width; must hold ITERS
) (
   input  logic        i_clk_1,
   input  logic        i_rstN_1,
   input  logic        i_inValid_1,
   output logic        o_inReady_1,
   input  logic [31:0] i_mulOperand1_32,
   input  logic [31:0] i_mulOperand2_32,
   output logic        o_outValid_1,
   input  logic        i_outReady_1,
   output logic [63:0] o_mulProduct_64,
   output logic        o_busy_1,
   output logic [31:0] o_adderOperand1_32,
   output logic [31:0] o_adderOperand2_32,
   output logic        o_adderCIn_1,
   input  logic [31:0] i_adderSum_32,
   input  logic        i_adderCOut_1
);

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [31:0]      mcand;    // multiplicand, captured at accept
   logic [31:0]      hi;       // upper half of the running product
   logic [31:0]      lo;       // lower product bits shifted in over unconsumed multiplier bits
   logic [31:0]      mrem;     // multiplier bits not yet consumed
   logic [CNT_W-1:0] cnt;      // iterations completed
   logic [63:0]      product;  // registered result; survives the return to IDLE

   logic        in_calc;
   logic        last_iter;
   logic        finish;
   logic [31:0] hi_iter;
   logic [31:0] lo_iter;

   assign in_calc   = (state == S_CALC);
   assign last_iter = (cnt == LAST_ITER);

   // One shift-add step. The carry-out is the 33rd bit of the partial sum.
   // It must enter hi[31], or the result is wrong for full-range operands.
   assign hi_iter = {i_adderCOut_1, i_adderSum_32[31:1]};
   assign lo_iter = {i_adderSum_32[0], lo[31:1]};

`ifdef ADDER_MUL_EARLY_TERM_EN
   localparam logic [CNT_W-1:0] ITERS_C = CNT_W'(ITERS);

   logic        early;
   logic [63:0] aligned;

   // When no multiplier bits remain, every later iteration would only shift
   // right by one. That is ITERS-cnt shifts in total. They collapse into
   // one barrel shift here. No stale multiplier bits remain in lo, because
   // all of them are already zero.
   assign early   = (mrem == '0);
   assign aligned = {hi, lo} >> (ITERS_C - cnt);
   assign finish  = early || last_iter;
`else
   assign finish  = last_iter;
`endif

   //--------------------------------------------------------------------------
   // State register
   //--------------------------------------------------------------------------
   // NOTE: Clocked processes use non-blocking assignments (<=). Every
   // register then updates from the values it had before the edge, in
   // whatever order the blocks are evaluated.
   always_ff @(posedge i_clk_1 or negedge i_rstN_1) begin
      if (!i_rstN_1) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   //--------------------------------------------------------------------------
   // Next-state logic
   //--------------------------------------------------------------------------
   // NOTE: state_nxt gets its default before the case statement. Every path
   // then assigns it, so no latch can be inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (i_inValid_1)  state_nxt = S_CALC;
         S_CALC: if (finish)       state_nxt = S_DONE;
         S_DONE: if (i_outReady_1) state_nxt = S_IDLE;
         default:                  state_nxt = S_IDLE;
      endcase
   end

   //--------------------------------------------------------------------------
   // Datapath registers
   //--------------------------------------------------------------------------
   always_ff @(posedge i_clk_1 or negedge i_rstN_1) begin
      if (!i_rstN_1) begin
         mcand   <= '0;
         hi      <= '0;
         lo      <= '0;
         mrem    <= '0;
         cnt     <= '0;
         product <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               // Operands are sampled only here. Later changes on the
               // inputs cannot disturb a multiply that is in flight.
               if (i_inValid_1) begin
                  mcand <= i_mulOperand1_32;
                  hi    <= '0;
                  lo    <= i_mulOperand2_32;
                  mrem  <= i_mulOperand2_32;
                  cnt   <= '0;
               end
            end

            S_CALC: begin
`ifdef ADDER_MUL_EARLY_TERM_EN
               if (early) begin
                  {hi, lo} <= aligned;
                  product  <= aligned;
               end else
`endif
               begin
                  hi   <= hi_iter;
                  lo   <= lo_iter;
                  mrem <= mrem >> 1;
                  cnt  <= cnt + CNT_W'(1);
                  if (last_iter) begin
                     product <= {hi_iter, lo_iter};
                  end
               end
            end

            default: ;  // DONE: hold everything until the consumer takes it
         endcase
      end
   end

   //--------------------------------------------------------------------------
   // Outputs
   //--------------------------------------------------------------------------
   assign o_inReady_1     = (state == S_IDLE);
   assign o_outValid_1    = (state == S_DONE);
   assign o_busy_1        = (state != S_IDLE);
   assign o_mulProduct_64 = product;

   // The shared adder is driven only in CALC. In IDLE and DONE the operands
   // are zero, and another master may use the adder while o_busy_1 is low.
   assign o_adderOperand1_32 = in_calc ? hi : '0;
   assign o_adderOperand2_32 = (in_calc && lo[0]) ? mcand : '0;
   assign o_adderCIn_1       = 1'b0;

endmodule

// File: tb/tb_adder_mul_seq.sv
//-----------------------------------------------------------------------------
// tb_adder_mul_seq
//
// Self-checking bench for adder_mul_seq. It models the shared 32-bit adder
// combinationally. It applies a table of directed multiply vectors, then
// hand-written sequences for:
//   - an ignored request during CALC,
//   - a request that arrives while DONE is being accepted,
//   - a reset in the middle of a multiply.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_adder_mul_seq;

   logic        i_clk_1 = 1'b0;
   logic        i_rstN_1;
   logic        i_inValid_1;
   logic        o_inReady_1;
   logic [31:0] i_mulOperand1_32;
   logic [31:0] i_mulOperand2_32;
   logic        o_outValid_1;
   logic        i_outReady_1;
   logic [63:0] o_mulProduct_64;
   logic        o_busy_1;
   logic [31:0] o_adderOperand1_32;
   logic [31:0] o_adderOperand2_32;
   logic        o_adderCIn_1;
   logic [31:0] i_adderSum_32;
   logic        i_adderCOut_1;

   // Shared adder model: 32-bit add with carry-in and carry-out.
   logic [32:0] add_res;
   assign add_res       = {1'b0, o_adderOperand1_32} + {1'b0, o_adderOperand2_32}
                          + {32'b0, o_adderCIn_1};
   assign i_adderSum_32 = add_res[31:0];
   assign i_adderCOut_1 = add_res[32];

   adder_mul_seq dut (
      .i_clk_1            (i_clk_1),
      .i_rstN_1           (i_rstN_1),
      .i_inValid_1        (i_inValid_1),
      .o_inReady_1        (o_inReady_1),
      .i_mulOperand1_32   (i_mulOperand1_32),
      .i_mulOperand2_32   (i_mulOperand2_32),
      .o_outValid_1       (o_outValid_1),
      .i_outReady_1       (i_outReady_1),
      .o_mulProduct_64    (o_mulProduct_64),
      .o_busy_1           (o_busy_1),
      .o_adderOperand1_32 (o_adderOperand1_32),
      .o_adderOperand2_32 (o_adderOperand2_32),
      .o_adderCIn_1       (o_adderCIn_1),
      .i_adderSum_32      (i_adderSum_32),
      .i_adderCOut_1      (i_adderCOut_1)
   );

   always #5 i_clk_1 = ~i_clk_1;

   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_total++;
      if (got === want) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
      end
   endtask

   // Number of CALC cycles expected for a given multiplier.
   function automatic int exp_calc(input logic [31:0] m);
`ifdef ADDER_MUL_EARLY_TERM_EN
      int msb;
      if (m == 32'd0) return 1;
      msb = 0;
      for (int i = 0; i < 32; i++) if (m[i]) msb = i;
      return (msb + 2 > 32) ? 32 : msb + 2;
`else
      return 32;
`endif
   endfunction

   // Adder operands and carry-in, packed for a single "must be zero" check.
   function automatic logic [63:0] adder_bus();
      return {31'b0, o_adderCIn_1, o_adderOperand1_32 | o_adderOperand2_32};
   endfunction

   // Runs one multiply. The call must start #1 after a rising edge. The
   // operands are corrupted after the accept edge, to show that the block
   // captured them at accept. The task holds i_outReady_1 low for `hold`
   // cycles in DONE.
   task automatic do_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] want, input int hold);
      int n;
      i_mulOperand1_32 = a;
      i_mulOperand2_32 = b;
      i_inValid_1      = 1'b1;
      i_outReady_1     = (hold == 0);
      n = 0;
      while (!o_inReady_1 && n < 100) begin
         @(posedge i_clk_1); #1; n++;
      end
      check({name, " in_ready"}, {63'b0, o_inReady_1}, 64'd1);
      @(posedge i_clk_1); #1;            // accept edge
      i_inValid_1      = 1'b0;
      i_mulOperand1_32 = ~a;
      i_mulOperand2_32 = ~b;
      check({name, " busy"}, {63'b0, o_busy_1}, 64'd1);
      n = 0;
      while (!o_outValid_1 && n < 100) begin
         @(posedge i_clk_1); #1; n++;
      end
      check({name, " latency"}, 64'(n), 64'(exp_calc(b)));
      check({name, " product"}, o_mulProduct_64, want);
      check({name, " adder idle in DONE"}, adder_bus(), 64'd0);
      for (int i = 0; i < hold; i++) begin
         @(posedge i_clk_1); #1;
         check({name, " held"}, {63'b0, o_outValid_1 && (o_mulProduct_64 == want)}, 64'd1);
      end
      i_outReady_1 = 1'b1;
      @(posedge i_clk_1); #1;            // handshake edge
      check({name, " valid drop"}, {63'b0, o_outValid_1}, 64'd0);
      check({name, " product kept"}, o_mulProduct_64, want);
      check({name, " adder idle in IDLE"}, adder_bus(), 64'd0);
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] p;
      int          hold;
   } vec_t;

   vec_t vecs[9];

   initial begin
      int n;
      int valid_seen;

      vecs[0] = '{32'd3,          32'd5,          64'h0000_0000_0000_000F, 0};
      vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, 0};
      vecs[2] = '{32'h1234_5678,  32'h0,          64'h0,                   10};
      vecs[3] = '{32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000, 0};
      vecs[4] = '{32'h8000_0000,  32'd2,          64'h0000_0001_0000_0000, 0};
      vecs[5] = '{32'hDEAD_BEEF,  32'd1,          64'h0000_0000_DEAD_BEEF, 0};
      vecs[6] = '{32'hFFFF_FFFF,  32'd2,          64'h0000_0001_FFFF_FFFE, 0};
      vecs[7] = '{32'd1,          32'h8000_0000,  64'h0000_0000_8000_0000, 0};
      vecs[8] = '{32'h0001_0001,  32'h0001_0001,  64'h0000_0001_0002_0001, 0};

      i_rstN_1         = 1'b0;
      i_inValid_1      = 1'b0;
      i_outReady_1     = 1'b0;
      i_mulOperand1_32 = '0;
      i_mulOperand2_32 = '0;
      repeat (3) @(posedge i_clk_1);
      #1;
      check("rst in_ready",  {63'b0, o_inReady_1},  64'd1);
      check("rst out_valid", {63'b0, o_outValid_1}, 64'd0);
      check("rst busy",      {63'b0, o_busy_1},     64'd0);
      check("rst product",   o_mulProduct_64,       64'd0);
      check("rst adder",     adder_bus(),           64'd0);
      i_rstN_1 = 1'b1;
      @(posedge i_clk_1); #1;

      // Directed vectors, issued back to back.
      for (int v = 0; v < 9; v++) begin
         do_mul($sformatf("vec%0d", v), vecs[v].a, vecs[v].b, vecs[v].p, vecs[v].hold);
      end

      // A second request during CALC, with new operands, is ignored. The
      // same request is still high while DONE is accepted. It must wait for
      // the following IDLE cycle.
      i_mulOperand1_32 = 32'h1234_5678;
      i_mulOperand2_32 = 32'd5;
      i_inValid_1      = 1'b1;
      i_outReady_1     = 1'b1;
      @(posedge i_clk_1); #1;            // accept (block is IDLE)
      i_inValid_1 = 1'b0;
      repeat (3) @(posedge i_clk_1);
      #1;
      i_mulOperand1_32 = 32'd3;
      i_mulOperand2_32 = 32'h0000_FFFF;
      i_inValid_1      = 1'b1;
      check("calc in_ready low", {63'b0, o_inReady_1}, 64'd0);
      n = 0;
      while (!o_outValid_1 && n < 100) begin
         @(posedge i_clk_1); #1; n++;
      end
      check("first product", o_mulProduct_64, 64'h0000_0000_5B05_B058);
      check("done in_ready low", {63'b0, o_inReady_1}, 64'd0);
      @(posedge i_clk_1); #1;            // DONE handshake; request not taken
      check("not taken at done", {63'b0, o_busy_1}, 64'd0);
      @(posedge i_clk_1); #1;            // taken in IDLE
      check("taken after idle", {63'b0, o_busy_1}, 64'd1);
      i_inValid_1 = 1'b0;
      n = 0;
      while (!o_outValid_1 && n < 100) begin
         @(posedge i_clk_1); #1; n++;
      end
      check("second product", o_mulProduct_64, 64'h0000_0000_0002_FFFD);
      @(posedge i_clk_1); #1;

      // Reset when cnt==17: everything clears at once, with no later output pulse.
      i_mulOperand1_32 = 32'hFFFF_FFFF;
      i_mulOperand2_32 = 32'hFFFF_FFFF;
      i_inValid_1      = 1'b1;
      @(posedge i_clk_1); #1;            // accept
      i_inValid_1 = 1'b0;
      repeat (17) @(posedge i_clk_1);
      #3;
      i_rstN_1 = 1'b0;
      #1;
      check("midrst in_ready",  {63'b0, o_inReady_1},  64'd1);
      check("midrst out_valid", {63'b0, o_outValid_1}, 64'd0);
      check("midrst busy",      {63'b0, o_busy_1},     64'd0);
      check("midrst product",   o_mulProduct_64,       64'd0);
      check("midrst adder",     adder_bus(),           64'd0);
      #2;
      i_rstN_1 = 1'b1;
      valid_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge i_clk_1); #1;
         if (o_outValid_1) valid_seen++;
      end
      check("no pulse after reset", 64'(valid_seen), 64'd0);
      do_mul("post-reset 7x9", 32'd7, 32'd9, 64'h0000_0000_0000_003F, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog timeout");
   end

endmodule
